// File: rtl/regfile_pkg.sv
// Shared types and constants for the register file access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int DW = 32;
    localparam int AW = 5;

    // Hardwired $zero register number.
    localparam int unsigned REG_ZERO = 0;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ_RS = 3'd2,
        READ_RT = 3'd3,
        RESP    = 3'd4
    } rfseq_state_t;

endpackage

// File: rtl/rfseq_port_driver.sv
// Decodes sequencer state + latched request fields into register file port controls.
// Latency: combinational from registered state, no input-to-output path from handshakes.
// Backpressure: none; the port is driven only in WRITE/READ_RS/READ_RT, idle otherwise.
//
// Ports:
//   state                       current sequencer state (registered in the top)
//   wb_en, wb_addr, wb_data     latched write-back request
//   rs_addr, rt_addr            latched source register numbers
//   rf_addr, rf_istream         register file address / write data
//   rf_write_mode, rf_read_mode, rf_chip_select   register file controls
module rfseq_port_driver
    import regfile_pkg::*;
#(
    parameter int DW = regfile_pkg::DW,
    parameter int AW = regfile_pkg::AW
) (
    input  rfseq_state_t  state,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_istream,
    output logic          rf_write_mode,
    output logic          rf_read_mode,
    output logic          rf_chip_select
);

    // Each state drives at most one mode, so read and write can never overlap.
    // The write arm re-checks wb_en and $zero so a stray WRITE state can
    // never corrupt register 0.
    always_comb begin
        rf_addr        = '0;
        rf_istream     = '0;
        rf_write_mode  = 1'b0;
        rf_read_mode   = 1'b0;
        rf_chip_select = 1'b0;
        case (state)
            WRITE: begin
                if (wb_en && (wb_addr != AW'(REG_ZERO))) begin
                    rf_chip_select = 1'b1;
                    rf_write_mode  = 1'b1;
                    rf_addr        = wb_addr;
                    rf_istream     = wb_data;
                end
            end
            READ_RS: begin
                rf_chip_select = 1'b1;
                rf_read_mode   = 1'b1;
                rf_addr        = rs_addr;
            end
            READ_RT: begin
                rf_chip_select = 1'b1;
                rf_read_mode   = 1'b1;
                rf_addr        = rt_addr;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/regfile_access_sequencer.sv
// Serializes write-back, rs read and rt read onto the single register file port.
// Latency: accept -> resp_valid in 4 cycles with a write, 3 without ($zero writes skipped).
// Backpressure: holds operands in RESP until resp_ready; req_ready low outside IDLE.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (rs_addr, rt_addr, wb_en, wb_addr, wb_data)
//   resp_valid/resp_ready        response handshake (rs_data, rt_data)
//   rf_addr, rf_istream, rf_write_mode, rf_read_mode, rf_chip_select   to register file
//   rf_ostream                   register file read data, sampled at the end of a read cycle
module regfile_access_sequencer
    import regfile_pkg::*;
#(
    parameter int DW = regfile_pkg::DW,
    parameter int AW = regfile_pkg::AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_istream,
    output logic          rf_write_mode,
    output logic          rf_read_mode,
    output logic          rf_chip_select,
    input  logic [DW-1:0] rf_ostream
);

    rfseq_state_t  state;
    logic [AW-1:0] rs_q;
    logic [AW-1:0] rt_q;
    logic          wb_en_q;
    logic [AW-1:0] wb_addr_q;
    logic [DW-1:0] wb_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            rs_data    <= '0;
            rt_data    <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        rs_q      <= rs_addr;
                        rt_q      <= rt_addr;
                        wb_en_q   <= wb_en;
                        wb_addr_q <= wb_addr;
                        wb_data_q <= wb_data;
                        req_ready <= 1'b0;
                        // $zero writes are dropped here so they cost no port cycle.
                        if (wb_en && (wb_addr != AW'(REG_ZERO))) begin
                            state <= WRITE;
                        end else begin
                            state <= READ_RS;
                        end
                    end
                end
                WRITE: begin
                    state <= READ_RS;
                end
                READ_RS: begin
                    rs_data <= (rs_q == AW'(REG_ZERO)) ? '0 : rf_ostream;
                    state   <= READ_RT;
                end
                READ_RT: begin
                    rt_data    <= (rt_q == AW'(REG_ZERO)) ? '0 : rf_ostream;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    // req_ready rises only after the response leaves, so no
                    // accept can overlap the RESP cycle.
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

    rfseq_port_driver #(
        .DW (DW),
        .AW (AW)
    ) u_port_driver (
        .state          (state),
        .wb_en          (wb_en_q),
        .wb_addr        (wb_addr_q),
        .wb_data        (wb_data_q),
        .rs_addr        (rs_q),
        .rt_addr        (rt_q),
        .rf_addr        (rf_addr),
        .rf_istream     (rf_istream),
        .rf_write_mode  (rf_write_mode),
        .rf_read_mode   (rf_read_mode),
        .rf_chip_select (rf_chip_select)
    );

endmodule

// File: doc/regfile_access_sequencer.md
# regfile_access_sequencer

Decode-side front end for the single-port 32x32 register file. Accepts one operand request per transaction (write-back value plus two source reads), serializes the write, the rs read and the rt read onto the register file's one address/data port, and returns both operands with a valid/ready handshake. Sits between the ID stage control logic and `register_file`. Enforces MIPS write-before-read ordering and hardwired `$zero`.

## Interface
Parameters:
- `DW`, 32, data width; must match register file word.
- `AW`, 5, register address width.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  sequencer can accept request.
- `rs_addr`, `rt_addr`  in  AW  source register numbers.
- `wb_en`  in  1  write-back requested.
- `wb_addr`  in  AW  write-back register number.
- `wb_data`  in  DW  write-back value.
- `resp_valid`  out  1  operands available.
- `resp_ready`  in  1  consumer takes operands.
- `rs_data`, `rt_data`  out  DW  operand values.
- `rf_addr`  out  AW  to register file `addr`.
- `rf_istream`  out  DW  to register file `istream`.
- `rf_write_mode`, `rf_read_mode`, `rf_chip_select`  out  1  to register file controls.
- `rf_ostream`  in  DW  from register file `ostream`.

Decided: one clock; reset is synchronous and active-high.

## Operation
- FSM states: IDLE, WRITE, READ_RS, READ_RT, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch rs_addr, rt_addr, wb_en, wb_addr, wb_data. Next = WRITE if `wb_en && wb_addr!=0`, else READ_RS.
- WRITE: `rf_chip_select`=1, `rf_write_mode`=1, `rf_read_mode`=0, `rf_addr`=latched wb_addr, `rf_istream`=latched wb_data. One cycle. Next READ_RS.
- READ_RS: `rf_chip_select`=1, `rf_read_mode`=1, `rf_write_mode`=0, `rf_addr`=rs. At cycle end capture `rf_ostream` into rs_data, or 0 if rs==0. Next READ_RT.
- READ_RT: same for rt into rt_data. Next RESP.
- RESP: `resp_valid`=1; rs_data/rt_data held stable. On `resp_ready`: go IDLE.
- Writes to register 0 suppressed (no WRITE cycle). Reads of register 0 still occupy a port cycle but return 0 regardless of `rf_ostream`.
- Write precedes reads, so a read of wb_addr in the same transaction returns wb_data.
- In IDLE and RESP: all rf controls 0, `rf_addr`=0, `rf_istream`=0.
- `rf_write_mode` and `rf_read_mode` never both 1.

## Timing
- All outputs registered or decoded from registered state; no combinational path from `req_valid`/`resp_ready` to any output.
- Reset: state IDLE, `req_ready`=1, `resp_valid`=0, rs_data=rt_data=0, all rf_* outputs 0.
- Accept at edge N. With write: WRITE N+1, READ_RS N+2, READ_RT N+3, `resp_valid` from N+4. Without write: `resp_valid` from N+3.
- `resp_ready` sampled only in RESP; response consumed on edge where both valid and ready are 1; `req_ready` rises the following cycle (no accept in RESP; back-to-back throughput 1 per 4 or 5 cycles).
- `rst` mid-transaction: abort at next edge, rf controls deasserted same edge; write already issued stays committed, pending one is dropped.
- Request inputs ignored outside IDLE.

## Structure
- Shared package `regfile_pkg`: `DW`, `AW`, state enum `rfseq_state_t`, constant `REG_ZERO`=0.
- One sub-module natural: `rfseq_port_driver` — combinational decode from state + latched fields to rf_* controls (guarantees mutual exclusion of read/write modes).
- Top instantiates sequencer with real `register_file` for integration bench.

## Test plan
- Reset then idle: after `rst` 2 cycles -> `req_ready`=1, `resp_valid`=0, rf_* all 0, operands 0.
- Write then read-back: req wb_en=1 wb_addr=5 wb_data=0xDEADBEEF, rs=5, rt=0 -> WRITE cycle with rf_addr=5; `resp_valid` at N+4; rs_data=0xDEADBEEF, rt_data=0.
- No write: preload r3=0x11, r7=0x22; req wb_en=0 rs=3 rt=7 -> no write_mode pulse; `resp_valid` at N+3; 0x11/0x22.
- Zero register: req wb_en=1 wb_addr=0 wb_data=0xFFFFFFFF, rs=0 rt=0 -> no WRITE state, both operands 0, latency 3.
- Backpressure: hold `resp_ready`=0 for 5 cycles -> `resp_valid` stays 1, data stable, `req_ready`=0, new `req_valid` ignored; release -> IDLE next cycle.
- Reset mid-READ_RS: assert `rst` -> next edge IDLE, `rf_read_mode`=0, `resp_valid` never asserted; earlier write to r9 still reads back.
